// File: rtl/led_step_controller.sv
// 3-LED thermometer bar sequencer: synchronized/debounced switch presses and auto ticks step a level FSM.
// Optional LED_BOUNCE_EN selects a ping-pong level sequence instead of wrapping from L3 back to L0.
module led_step_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw,
  input  logic       auto_en,
  input  logic       clear,
  output logic [2:0] led,
  output logic [1:0] level,
  output logic       step_o
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PSW = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    L0 = 2'd0,
    L1 = 2'd1,
    L2 = 2'd2,
    L3 = 2'd3
  } lvl_e;

  // Switch synchronizer; sync_vld marks when sync2 holds a real post-reset sample.
  logic       sync1;
  logic       sync2;
  logic [1:0] sync_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sync_vld <= 2'b00;
    end else begin
      sync1    <= sw;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  logic           sw_deb;
  logic [DBW-1:0] db_cnt;
  logic           db_flip;
  logic           man_arm;
  logic           man_req;

  assign db_flip = (sync2 != sw_deb) && (db_cnt == DB_LAST);

  // man_arm stays low until a genuine released level is seen, so a switch held
  // down through reset cannot fake a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_deb  <= 1'b1;
      db_cnt  <= '0;
      man_arm <= 1'b0;
      man_req <= 1'b0;
    end else begin
      if (sync2 == sw_deb) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        db_cnt <= '0;
        sw_deb <= sync2;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
      man_req <= db_flip && !sync2 && man_arm;
      if (sync_vld[1] && sync2) begin
        man_arm <= 1'b1;
      end
    end
  end

  logic [PSW-1:0] presc;
  logic           auto_req;

  assign auto_req = auto_en && (presc == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear || !auto_en || (presc == PS_LAST)) begin
      presc <= '0;
    end else begin
      presc <= presc + PSW'(1);
    end
  end

  // Simultaneous manual and auto requests merge into a single step.
  logic step_req;

  assign step_req = !clear && (man_req || auto_req);

  lvl_e state;
  lvl_e state_nxt;
`ifdef LED_BOUNCE_EN
  logic dir_dn;
  logic dir_dn_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= L0;
`ifdef LED_BOUNCE_EN
      dir_dn <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
`ifdef LED_BOUNCE_EN
      dir_dn <= dir_dn_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef LED_BOUNCE_EN
    dir_dn_nxt = dir_dn;
`endif
    if (clear) begin
      state_nxt = L0;
`ifdef LED_BOUNCE_EN
      dir_dn_nxt = 1'b0;
`endif
    end else if (step_req) begin
`ifdef LED_BOUNCE_EN
      if (!dir_dn) begin
        case (state)
          L0: state_nxt = L1;
          L1: state_nxt = L2;
          L2: begin
            state_nxt  = L3;
            dir_dn_nxt = 1'b1;
          end
          default: begin
            state_nxt  = L2;
            dir_dn_nxt = 1'b1;
          end
        endcase
      end else begin
        case (state)
          L3: state_nxt = L2;
          L2: state_nxt = L1;
          L1: begin
            state_nxt  = L0;
            dir_dn_nxt = 1'b0;
          end
          default: begin
            state_nxt  = L1;
            dir_dn_nxt = 1'b0;
          end
        endcase
      end
`else
      case (state)
        L0:      state_nxt = L1;
        L1:      state_nxt = L2;
        L2:      state_nxt = L3;
        default: state_nxt = L0;
      endcase
`endif
    end
  end

  function automatic logic [2:0] bar_of(input lvl_e s);
    case (s)
      L0:      bar_of = 3'b000;
      L1:      bar_of = 3'b001;
      L2:      bar_of = 3'b011;
      default: bar_of = 3'b111;
    endcase
  endfunction

  // Outputs are loaded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= 3'b000;
      level  <= 2'd0;
      step_o <= 1'b0;
    end else begin
      led    <= bar_of(state_nxt);
      level  <= state_nxt;
      step_o <= step_req;
    end
  end

endmodule

// File: tb/tb_led_step_controller.sv
// Bench for led_step_controller: vector table, directed corner sequences and randomized
// stimulus compared against a sample-history reference model.
`timescale 1ns/1ps
module tb_led_step_controller;

  localparam int DEB  = 4;
  localparam int TDIV = 8;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       sw      = 1'b1;
  logic       auto_en = 1'b0;
  logic       clear   = 1'b0;
  logic [2:0] led;
  logic [1:0] level;
  logic       step_o;

  int n_chk  = 0;
  int n_pass = 0;

  led_step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV       (TDIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .auto_en(auto_en),
    .clear  (clear),
    .led    (led),
    .level  (level),
    .step_o (step_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: sample history of sw, step count, run length of enabled cycles.
  bit m_smp[0:DEB];
  int m_vcnt;
  bit m_deb;
  bit m_armed;
  bit m_pend;
  int m_auto_run;
  int m_steps;
  bit m_step;

  function automatic int m_level();
`ifdef LED_BOUNCE_EN
    int s;
    s = m_steps % 6;
    return (s <= 3) ? s : 6 - s;
`else
    return m_steps % 4;
`endif
  endfunction

  function automatic int bar(input int lv);
    return (1 << lv) - 1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= DEB; j++) m_smp[j] = 1'b1;
    m_vcnt = 0; m_deb = 1'b1; m_armed = 1'b0; m_pend = 1'b0;
    m_auto_run = 0; m_steps = 0; m_step = 1'b0;
  endtask

  task automatic model_edge();
    bit tick;
    bit all_diff;
    tick       = auto_en && (m_auto_run % TDIV == TDIV - 1);
    m_step     = !clear && (m_pend || tick);
    m_auto_run = (auto_en && !clear) ? m_auto_run + 1 : 0;
    if (clear) m_steps = 0;
    else if (m_step) m_steps++;
    // The debounced level flips once the last DEB synchronized samples all disagree with it.
    all_diff = 1'b1;
    for (int j = 1; j <= DEB; j++) if (m_smp[j] == m_deb) all_diff = 1'b0;
    m_pend = all_diff && m_deb && m_armed;
    if (m_vcnt >= 2 && m_smp[1]) m_armed = 1'b1;
    if (all_diff) m_deb = !m_deb;
    for (int j = DEB; j > 0; j--) m_smp[j] = m_smp[j-1];
    m_smp[0] = sw;
    if (m_vcnt < 2) m_vcnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("model_led",   led,    bar(m_level()));
    check("model_level", level,  m_level());
    check("model_step",  step_o, m_step);
  endtask

  task automatic pulse_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_led",   led,    0);
    check("rst_level", level,  0);
    check("rst_step",  step_o, 0);
    repeat (hold) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    bit       sw;
    bit       auto_en;
    bit       clear;
    bit [2:0] led;
    bit [1:0] level;
    bit       step;
  } vec_t;

  vec_t       tbl[30];
  int         st_edge[$];
  bit [2:0]   st_led[$];
  bit [2:0]   exp_auto_led[5];
  int         nsteps;
  int         step_at;
  int         hold;
  bit         bounce_sw[19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 30; i++) begin
      tbl[i].sw      = (i >= 20);
      tbl[i].auto_en = 1'b0;
      tbl[i].clear   = 1'b0;
      tbl[i].led     = (i >= 6) ? 3'b001 : 3'b000;
      tbl[i].level   = (i >= 6) ? 2'd1 : 2'd0;
      tbl[i].step    = (i == 6);
    end
    for (int i = 0; i < 19; i++) bounce_sw[i] = !((i < 3) || (i >= 5 && i < 8));
    exp_auto_led[0] = 3'b001;
    exp_auto_led[1] = 3'b011;
    exp_auto_led[2] = 3'b111;
`ifdef LED_BOUNCE_EN
    exp_auto_led[3] = 3'b011;
`else
    exp_auto_led[3] = 3'b000;
`endif
    exp_auto_led[4] = 3'b001;

    // Power-on reset
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("por_led",   led,    0);
    check("por_level", level,  0);
    check("por_step",  step_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) cycle();

    // Clean press held, then released: one step on the 7th edge, nothing on release
    for (int i = 0; i < 30; i++) begin
      sw = tbl[i].sw; auto_en = tbl[i].auto_en; clear = tbl[i].clear;
      cycle();
      check($sformatf("tbl_led[%0d]", i),   led,    tbl[i].led);
      check($sformatf("tbl_level[%0d]", i), level,  tbl[i].level);
      check($sformatf("tbl_step[%0d]", i),  step_o, tbl[i].step);
    end

    // Glitchy press shorter than the debounce window
    clear = 1'b1; cycle(); clear = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 19; i++) begin
      sw = bounce_sw[i];
      cycle();
      if (step_o) nsteps++;
    end
    check("bounce_steps", nsteps, 0);
    check("bounce_led",   led,    0);

    // Auto stepping every TDIV edges from auto_en rising
    auto_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (step_o) begin
        st_edge.push_back(k);
        st_led.push_back(led);
      end
    end
    check("auto_count", st_edge.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("auto_edge[%0d]", k), (k < st_edge.size()) ? st_edge[k] : -1, TDIV * (k + 1));
      check($sformatf("auto_led[%0d]", k),  (k < st_led.size()) ? int'(st_led[k]) : -1, exp_auto_led[k]);
    end

    // Manual press landing on the same edge as an auto tick
    cycle();
    sw = 1'b0;
    nsteps = 0; step_at = -1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (step_o) begin nsteps++; step_at = k; end
    end
    check("coin_steps", nsteps, 1);
    check("coin_edge",  step_at, 7);
`ifdef LED_BOUNCE_EN
    check("coin_level", level, 0);
`else
    check("coin_level", level, 2);
`endif
    auto_en = 1'b0; sw = 1'b1;
    repeat (10) cycle();

    // Clear coinciding with an auto tick at level 2
    clear = 1'b1; cycle(); clear = 1'b0;
    auto_en = 1'b1;
    repeat (TDIV * 3 - 1) cycle();
    check("clr_pre_level", level, 2);
    clear = 1'b1;
    cycle();
    check("clr_level", level, 0);
    check("clr_led",   led,   0);
    check("clr_step",  step_o, 0);
    clear = 1'b0;
    step_at = -1;
    for (int k = 1; k <= TDIV; k++) begin
      cycle();
      if (step_o && step_at < 0) step_at = k;
    end
    check("clr_next_edge", step_at, TDIV);
    check("clr_next_level", level, 1);

    // Reset mid-operation with the switch held down
    sw = 1'b0; auto_en = 1'b1;
    repeat (3) cycle();
    pulse_reset(2);
    auto_en = 1'b0;
    nsteps = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (step_o) nsteps++;
    end
    check("held_rst_steps", nsteps, 0);
    check("held_rst_level", level,  0);
    sw = 1'b1;
    repeat (10) cycle();
    sw = 1'b0;
    step_at = -1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (step_o && step_at < 0) step_at = k;
    end
    check("repress_edge",  step_at, DEB + 3);
    check("repress_level", level,   1);

    // Randomized traffic against the model
    sw = 1'b1; hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        sw   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      clear = ($urandom_range(0, 49) == 0);
      cycle();
      if ($urandom_range(0, 599) == 0) pulse_reset($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
